// File: rtl/ex20_pkg.sv
// ============================================================================
// Module : ex20_pkg
// Brief  : Shared width defaults for the ex20 decoder/activity-counter block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ex20_pkg;
    localparam int IN_W_DEF  = 3;
    localparam int CNT_W_DEF = 8;
    localparam int N_OUT     = 2 ** IN_W_DEF;
endpackage

`default_nettype wire

// File: rtl/ex20_if.sv
// ============================================================================
// Module : ex20_if
// Brief  : Decode, registered-decode and counter read-back signal bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ex20_if
    import ex20_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic                 en;
    logic [IN_W-1:0]      in;
    logic [2**IN_W-1:0]   out;
    logic [2**IN_W-1:0]   out_q;
    logic                 clr;
    logic [IN_W-1:0]      rd_sel;
    logic [CNT_W-1:0]     rd_cnt;
    logic                 any_sat;

    modport master (
        output en, in, clr, rd_sel,
        input  out, out_q, rd_cnt, any_sat
    );

    modport slave (
        input  en, in, clr, rd_sel,
        output out, out_q, rd_cnt, any_sat
    );
endinterface

`default_nettype wire

// File: rtl/ex20_dec.sv
// ============================================================================
// Module : ex20_dec
// Brief  : Pure combinational one-hot decoder with enable.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex20_dec
    import ex20_pkg::*;
#(
    parameter int IN_W = IN_W_DEF
) (
    input  wire logic                en,
    input  wire logic [IN_W-1:0]     in,
    output      logic [2**IN_W-1:0]  out
);
    localparam int NO = 2 ** IN_W;

    assign out = en ? ({{(NO-1){1'b0}}, 1'b1} << in) : '0;
endmodule

`default_nettype wire

// File: rtl/ex20.sv
// ============================================================================
// Module : ex20
// Brief  : Decoder with registered copy and saturating per-line activity counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex20
    import ex20_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input wire logic clk,
    input wire logic rst,
    ex20_if.slave    bus
);
    localparam int               NO      = 2 ** IN_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [NO];
    logic             any_sat;

    ex20_dec #(.IN_W(IN_W)) u_dec (
        .en  (bus.en),
        .in  (bus.in),
        .out (bus.out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_q <= '0;
        end else begin
            bus.out_q <= bus.out;
        end
    end

    // Clear wins over increment; a saturated line simply holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NO; i++) cnt[i] <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < NO; i++) cnt[i] <= '0;
        end else if (bus.en && (cnt[bus.in] != CNT_MAX)) begin
            cnt[bus.in] <= cnt[bus.in] + 1'b1;
        end
    end

    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i < NO; i++) begin
            if (cnt[i] == CNT_MAX) any_sat = 1'b1;
        end
    end

    assign bus.rd_cnt  = cnt[bus.rd_sel];
    assign bus.any_sat = any_sat;
endmodule

`default_nettype wire

// File: tb/tb_ex20.sv
// ============================================================================
// Module : tb_ex20
// Brief  : Directed self-checking bench for ex20.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex20;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex20_if #(.IN_W(3), .CNT_W(8)) bus ();

    ex20 #(.IN_W(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.in     = 3'b000;
        bus.clr    = 1'b0;
        bus.rd_sel = 3'b000;

        // Reset state
        tick(1);
        chk("rst_out_q",   32'(bus.out_q),   32'h00);
        chk("rst_rd_cnt",  32'(bus.rd_cnt),  32'h00);
        chk("rst_any_sat", 32'(bus.any_sat), 32'h0);

        // Pure decode, under reset and without an intervening edge
        #1; chk("dec_en0",   32'(bus.out), 32'h00);
        bus.en = 1'b1; bus.in = 3'b000; #1; chk("dec_000", 32'(bus.out), 32'h01);
        bus.in = 3'b001; #1; chk("dec_001", 32'(bus.out), 32'h02);
        bus.in = 3'b010; #1; chk("dec_010", 32'(bus.out), 32'h04);
        bus.in = 3'b100; #1; chk("dec_100", 32'(bus.out), 32'h10);
        bus.in = 3'b111; #1; chk("dec_111", 32'(bus.out), 32'h80);
        bus.en = 1'b0;   #1; chk("dec_off", 32'(bus.out), 32'h00);
        chk("rst_hold_q", 32'(bus.out_q), 32'h00);

        tick(1);
        rst = 1'b0;

        // Registered copy
        bus.en = 1'b1; bus.in = 3'b011;
        tick(1);
        chk("out_q_011", 32'(bus.out_q), 32'h08);
        bus.en = 1'b0;
        tick(1);
        chk("out_q_off", 32'(bus.out_q), 32'h00);
        bus.rd_sel = 3'b011; #1;
        chk("cnt3_one", 32'(bus.rd_cnt), 32'd1);

        bus.clr = 1'b1;
        tick(1);
        bus.clr = 1'b0;
        chk("cnt3_clr", 32'(bus.rd_cnt), 32'd0);

        // Three increments on line 5
        bus.en = 1'b1; bus.in = 3'b101;
        tick(3);
        bus.en = 1'b0;
        bus.rd_sel = 3'b101; #1; chk("cnt5_three", 32'(bus.rd_cnt), 32'd3);
        bus.rd_sel = 3'b000; #1; chk("cnt0_zero",  32'(bus.rd_cnt), 32'd0);
        chk("sat_none", 32'(bus.any_sat), 32'h0);

        // Idle edges leave counters alone
        tick(4);
        bus.rd_sel = 3'b101; #1; chk("cnt5_idle", 32'(bus.rd_cnt), 32'd3);

        // Saturation on line 2
        bus.en = 1'b1; bus.in = 3'b010;
        tick(254);
        bus.en = 1'b0;
        bus.rd_sel = 3'b010; #1; chk("cnt2_254", 32'(bus.rd_cnt), 32'd254);
        chk("sat_254", 32'(bus.any_sat), 32'h0);
        bus.en = 1'b1;
        tick(6);
        bus.en = 1'b0;
        #1;
        chk("cnt2_sat", 32'(bus.rd_cnt), 32'd255);
        chk("sat_set",  32'(bus.any_sat), 32'h1);
        bus.rd_sel = 3'b101; #1; chk("cnt5_hold", 32'(bus.rd_cnt), 32'd3);

        // Clear beats a simultaneous increment
        bus.clr = 1'b1; bus.en = 1'b1; bus.in = 3'b010;
        tick(1);
        bus.clr = 1'b0; bus.en = 1'b0;
        bus.rd_sel = 3'b010; #1; chk("cnt2_clr", 32'(bus.rd_cnt), 32'd0);
        bus.rd_sel = 3'b101; #1; chk("cnt5_clr", 32'(bus.rd_cnt), 32'd0);
        chk("sat_clr", 32'(bus.any_sat), 32'h0);

        // Asynchronous reset mid-count
        bus.en = 1'b1; bus.in = 3'b110; bus.rd_sel = 3'b110;
        tick(4);
        chk("cnt6_four", 32'(bus.rd_cnt), 32'd4);
        chk("out_q_110", 32'(bus.out_q), 32'h40);
        #2; rst = 1'b1; #1;
        chk("arst_out_q",  32'(bus.out_q),  32'h00);
        chk("arst_rd_cnt", 32'(bus.rd_cnt), 32'd0);
        chk("arst_out",    32'(bus.out),    32'h40);
        bus.in = 3'b111; #1;
        chk("arst_out_7",  32'(bus.out),    32'h80);
        tick(1);
        chk("arst_hold_q", 32'(bus.out_q),  32'h00);

        // Resume after reset release
        rst = 1'b0; bus.in = 3'b000; bus.rd_sel = 3'b000;
        tick(1);
        chk("resume_q",   32'(bus.out_q),  32'h01);
        chk("resume_cnt", 32'(bus.rd_cnt), 32'd1);
        bus.rd_sel = 3'b110; #1;
        chk("resume_cnt6", 32'(bus.rd_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/ex20.md
EX20 -- requirements
Module: ex20

Interface
REQ-001 SHALL have parameter IN_W, default 3, decoder select width; output width is 2**IN_W (8 at default).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-line activity counter.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port en  input  1  decoder enable.
REQ-007 SHALL have port in  input  IN_W  line select.
REQ-008 SHALL have port out  output  2**IN_W  combinational one-hot decode.
REQ-009 SHALL have port out_q  output  2**IN_W  registered copy of out.
REQ-010 SHALL have port clr  input  1  synchronous clear of all counters.
REQ-011 SHALL have port rd_sel  input  IN_W  counter read select.
REQ-012 SHALL have port rd_cnt  output  CNT_W  value of counter rd_sel.
REQ-013 SHALL have port any_sat  output  1  high when any counter is at its maximum.

Function
REQ-014 SHALL drive out = (1 << in) when en=1 and all zeros when en=0, purely combinationally, with no clock or reset dependence.
REQ-015 SHALL drive exactly one bit of out high whenever en=1 (bit index = unsigned value of in).
REQ-016 SHALL update out with zero clock latency when in or en changes, including while rst is asserted.
REQ-017 SHALL load out_q with the current out on every rising clk edge; latency one cycle.
REQ-018 SHALL keep one CNT_W-bit counter per output line, cnt[0..2**IN_W-1].
REQ-019 SHALL increment cnt[in] by one on a rising edge when en=1 and clr=0; other counters hold.
REQ-020 SHALL saturate each counter at 2**CNT_W-1 (no wrap-around).
REQ-021 SHALL clear all counters to 0 on a rising edge when clr=1; clr has priority over a simultaneous increment.
REQ-022 SHALL not change any counter on edges with en=0 and clr=0.
REQ-023 SHALL drive rd_cnt = cnt[rd_sel] combinationally.
REQ-024 SHALL drive any_sat as the combinational OR over all counters of (cnt == 2**CNT_W-1).

Reset
REQ-025 SHALL, while rst=1, immediately force out_q to 0, all counters to 0 and hence rd_cnt=0 and any_sat=0, independent of clk.
REQ-026 SHALL resume normal register operation on the first rising clk edge after rst deasserts; reset applied mid-count discards all counts.

Structure
REQ-027 SHALL place IN_W default, CNT_W default and derived N_OUT = 2**IN_W in a shared package ex20_pkg.
REQ-028 SHALL implement the pure decode in one sub-module ex20_dec (inputs en, in; output out), instantiated once; out_q, counters, read mux and saturation flag reside in ex20.

Verification
REQ-029 SHALL verify en=0, in=000 -> out=00000000; en=1 with in=000/001/010/100/111 -> out=00000001/00000010/00000100/00010000/10000000; then en=0 -> out=00000000, each checked 1 time unit after the change with no clock edge.
REQ-030 SHALL verify en=1, in=011, one rising edge -> out_q=00001000; next edge with en=0 -> out_q=00000000.
REQ-031 SHALL verify three edges with en=1, in=101 then rd_sel=101 -> rd_cnt=3; rd_sel=000 -> rd_cnt=0.
REQ-032 SHALL verify 260 edges with en=1, in=010 (CNT_W=8) -> rd_cnt=255 for rd_sel=010 and any_sat=1; then clr=1 with en=1 for one edge -> all counters 0, any_sat=0.
REQ-033 SHALL verify rst asserted asynchronously between edges after counts accumulate -> out_q=0, rd_cnt=0 immediately, while out still follows en/in.
